// File: rtl/nibble_adder_bist.sv
// nibble_adder_bist
// Self-test sequencer for a registered nibble adder. Walks every {a,b}
// operand pair onto the adder input, waits out the adder latency, then
// compares the adder result against (a+b) mod 16 with a zero upper nibble.
// Keeps a saturating mismatch count and the index of the first mismatch.

module nibble_adder_bist #(
    parameter int LATENCY = 1,
    parameter int ERR_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [7:0]       op_out,
    input  logic [7:0]       sum_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       first_fail
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0]       CTR_LAST = 4'(LATENCY - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] idx;
    logic [3:0] ctr;
    logic       accept;
    logic       mismatch;

    // Reference result for a vector: low nibble is the 4-bit wrapped sum,
    // high nibble must always read back as zero.
    function automatic logic [7:0] expected_sum(input logic [7:0] v);
        logic [3:0] s;
        s = v[7:4] + v[3:0];
        return {4'b0000, s};
    endfunction

    // Error counter increment that sticks at all-ones.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (c == ERR_MAX) ? c : c + 1'b1;
    endfunction

    // A start is only honoured when no run is in flight.
    assign accept   = start && ((state == IDLE) || (state == DONE));
    // sum_in is only looked at in CHECK so an undriven bus elsewhere is harmless.
    assign mismatch = (state == CHECK) && (sum_in != expected_sum(idx));
    assign pass     = done && (err_count == '0);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: one DRIVE, LATENCY WAITs, one CHECK per vector.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE,
            DONE:    if (start) state_nxt = DRIVE;
            DRIVE:   state_nxt = WAIT;
            WAIT:    if (ctr == CTR_LAST) state_nxt = CHECK;
            CHECK:   state_nxt = (idx == 8'hFF) ? DONE : DRIVE;
            default: state_nxt = IDLE;
        endcase
    end

    // Vector index, operand drive, latency counter and result bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx        <= 8'h00;
            ctr        <= 4'd0;
            op_out     <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_count  <= '0;
            first_fail <= 8'h00;
        end else begin
            if (accept) begin
                idx        <= 8'h00;
                err_count  <= '0;
                first_fail <= 8'h00;
                done       <= 1'b0;
                busy       <= 1'b1;
            end

            if (state == DRIVE) begin
                op_out <= idx;
                ctr    <= 4'd0;
            end

            if (state == WAIT) begin
                ctr <= ctr + 4'd1;
            end

            if (state == CHECK) begin
                if (mismatch) begin
                    if (err_count == '0) first_fail <= idx;
                    err_count <= sat_inc(err_count);
                end
                if (idx == 8'hFF) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    idx <= idx + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_adder_bist.sv
// Bench for nibble_adder_bist: one sequencer at LATENCY=1 beside a
// one-stage adder model with selectable faults, one at LATENCY=2 beside a
// two-stage ideal adder. Expected run results and the expected operand
// sequence are queued when a run is started and checked as the DUT reports.

module tb_nibble_adder_bist;

    typedef struct {
        int cycles;
        int err;
        int ff;
        int pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start1, start2;
    logic [7:0] op1, op2, sum1, sum2, s2a;
    logic       busy1, done1, pass1, busy2, done2, pass2;
    logic [7:0] err1, err2, ff1, ff2;
    int         fault_mode;

    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];
    logic [7:0] op_q[$];

    always #5 clk = ~clk;

    nibble_adder_bist #(.LATENCY(1), .ERR_W(8)) u1 (
        .clk(clk), .reset(reset), .start(start1), .op_out(op1), .sum_in(sum1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_fail(ff1)
    );

    nibble_adder_bist #(.LATENCY(2), .ERR_W(8)) u2 (
        .clk(clk), .reset(reset), .start(start2), .op_out(op2), .sum_in(sum2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .first_fail(ff2)
    );

    function automatic logic [7:0] ideal(input logic [7:0] v);
        logic [3:0] s;
        s = v[7:4] + v[3:0];
        return {4'h0, s};
    endfunction

    // One-stage adder model with fault injection.
    always @(posedge clk) begin
        case (fault_mode)
            0:       sum1 <= ideal(op1);
            1:       sum1 <= ideal(op1) & 8'hFE;
            default: sum1 <= ideal(op1) | 8'h10;
        endcase
    end

    // Two-stage ideal adder model.
    always @(posedge clk) begin
        s2a  <= ideal(op2);
        sum2 <= s2a;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input int e, input int f, input int p);
        exp_t x;
        x.cycles = c; x.err = e; x.ff = f; x.pass = p;
        sb_q.push_back(x);
    endtask

    // Start a run on u1, optionally re-pulse start or assert reset at a given
    // cycle count after the start edge, then score against the queued result.
    task automatic run_u1(input string tag, input int glitch_n, input int reset_n);
        exp_t e;
        int   n;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        chk({tag, "_busy_start"}, 32'(busy1), 32'd1);
        chk({tag, "_done_clr"},   32'(done1), 32'd0);
        n = 0;
        while (done1 !== 1'b1 && n < 2000) begin
            @(posedge clk);
            n++;
            #1;
            if (n == glitch_n)          start1 = 1'b1;
            else if (n == glitch_n + 1) start1 = 1'b0;
            if (n == reset_n) begin
                reset = 1'b1;
                #1;
                e = sb_q.pop_front();
                chk({tag, "_rst_op"},   32'(op1),   32'd0);
                chk({tag, "_rst_busy"}, 32'(busy1), 32'd0);
                chk({tag, "_rst_done"}, 32'(done1), 32'd0);
                chk({tag, "_rst_pass"}, 32'(pass1), 32'(e.pass));
                chk({tag, "_rst_err"},  32'(err1),  32'(e.err));
                chk({tag, "_rst_ff"},   32'(ff1),   32'(e.ff));
                @(negedge clk);
                reset = 1'b0;
                return;
            end
        end
        e = sb_q.pop_front();
        chk({tag, "_cycles"}, 32'(n),     32'(e.cycles));
        chk({tag, "_done"},   32'(done1), 32'd1);
        chk({tag, "_busy"},   32'(busy1), 32'd0);
        chk({tag, "_pass"},   32'(pass1), 32'(e.pass));
        chk({tag, "_err"},    32'(err1),  32'(e.err));
        chk({tag, "_ff"},     32'(ff1),   32'(e.ff));
        chk({tag, "_op_end"}, 32'(op1),   32'hFF);
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        start1     = 1'b0;
        start2     = 1'b0;
        fault_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_op",   32'(op1),   32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_pass", 32'(pass1), 32'd0);
        chk("rst_err",  32'(err1),  32'd0);
        chk("rst_ff",   32'(ff1),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy1), 32'd0);

        // Ideal adder, full run.
        fault_mode = 0;
        push(768, 0, 0, 1);
        run_u1("t1", -1, -1);

        // sum[0] stuck at 0: every odd sum fails.
        fault_mode = 1;
        push(768, 128, 8'h01, 0);
        run_u1("t2", -1, -1);

        // Upper nibble stuck at 1: every vector fails, counter saturates.
        fault_mode = 2;
        push(768, 255, 8'h00, 0);
        run_u1("t3", -1, -1);

        // Start re-pulsed while vector 0x30 is on the bus is ignored.
        fault_mode = 0;
        push(768, 0, 0, 1);
        run_u1("t4", 8'h30 * 3 + 1, -1);

        // Reset while vector 0x40 is on the bus, then a fresh full run.
        push(0, 0, 0, 0);
        run_u1("t5r", -1, 8'h40 * 3 + 1);
        push(768, 0, 0, 1);
        run_u1("t5", -1, -1);

        // LATENCY=2: operand sequence and timing on the second instance.
        for (int i = 0; i < 256; i++) op_q.push_back(8'(i));
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        n = 0;
        while (done2 !== 1'b1 && n < 3000) begin
            @(posedge clk);
            n++;
            #1;
            if (((n - 1) % 4) == 0 && op_q.size() != 0)
                chk("t6_op", 32'(op2), 32'(op_q.pop_front()));
        end
        chk("t6_cycles", 32'(n),           32'd1024);
        chk("t6_pass",   32'(pass2),       32'd1);
        chk("t6_err",    32'(err2),        32'd0);
        chk("t6_opleft", 32'(op_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
